fetch_queue: RTL

Parametrised instruction fetch stage with its own program counter, a synchronous instruction memory, and a prefetch FIFO that decouples fetch from decode through a valid/ready handshake. A redirect from execute (branch or jump) flushes all fetched and in-flight words and restarts fetch at the redirect target. Sits between the pipeline front-end control and the decode stage. Each output entry is `{pc, word}`, and a bubble is all-zero.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_queue.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction fetch stage.
// The default entry type matches the default fetch_queue geometry
// (16-bit words, 512-word memory); wider or narrower instances build
// their own entry struct from the same {pc, word} layout.
package fetch_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 512;
  localparam int AW_DEF     = $clog2(DEPTH_DEF);

  typedef logic [AW_DEF-1:0]     addr_t;
  typedef logic [DATA_W_DEF-1:0] word_t;

  typedef struct packed {
    addr_t pc;
    word_t word;
  } fetch_entry_t;

  localparam word_t HALT_WORD_DEF = 16'hFFFF;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO between the fetch read stage and decode.
// Storage array with head/tail pointers and an occupancy count.
// Flush wins over push and pop in the same cycle. Storage is not reset;
// only the pointers and count are.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  QDEPTH  = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int PW      = $clog2(QDEPTH),
  localparam int CW      = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  input  logic          flush,
  output entry_t        head,
  output logic [CW-1:0] count
);

  entry_t        store [QDEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_push = push & !flush;
  assign do_pop  = pop & !flush & (count != '0);
  assign head    = store[head_ptr];

  // Entry storage: written on push, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) store[tail_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; flush empties the queue at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= ptr_next(tail_ptr);
      if (do_pop)  head_ptr <= ptr_next(head_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: program counter, synchronous instruction
// memory read stage and a prefetch FIFO towards decode.
// A redirect flushes everything fetched or in flight and restarts at the
// target. Issue is credit-limited so the read stage never overflows the FIFO.
// Optional halt detection is enabled with the macro FETCH_HALT_DETECT_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                DEPTH     = DEPTH_DEF,
  parameter int                QDEPTH    = 4,
  parameter int                RESET_PC  = 0,
  parameter string             INIT_FILE = "",
  parameter logic [DATA_W-1:0] HALT_WORD = HALT_WORD_DEF,
  localparam int               AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect_valid,
  input  logic [AW-1:0]        redirect_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AW+DATA_W-1:0] out_inst,
  output logic                 halted
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int OW = CW + 1;

  typedef struct packed {
    logic [AW-1:0]     pc;
    logic [DATA_W-1:0] word;
  } entry_t;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     pc_p0;
  logic              vld_p1;
  logic [AW-1:0]     rd_pc_p1;
  logic [DATA_W-1:0] rd_data_p1;

  entry_t            push_entry;
  entry_t            head_entry;
  logic [CW-1:0]     fifo_count;
  logic [OW-1:0]     occupancy;
  logic              pop;
  logic              issue;
  logic              halt_hit;
  logic              halted_q;

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  assign out_inst  = out_valid ? head_entry : '0;
  assign halted    = halted_q;

  // Occupancy the FIFO will have after this edge, counting the read in flight.
  assign occupancy = OW'(fifo_count) + OW'(vld_p1) - OW'(pop);
  assign issue     = !redirect_valid & !halted_q & !halt_hit &
                     (occupancy < OW'(QDEPTH));

  // ---- stage p0: program counter ----

  // PC advances on issue and is reloaded by a redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_p0  <= AW'(RESET_PC);
      vld_p1 <= 1'b0;
    end else if (redirect_valid) begin
      pc_p0  <= redirect_pc;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (issue) pc_p0 <= pc_p0 + AW'(1);
    end
  end

  // ---- stage p1: synchronous memory read ----

  // Capture the issued PC and its word; valid travels in vld_p1.
  always_ff @(posedge clk) begin
    if (issue) begin
      rd_pc_p1   <= pc_p0;
      rd_data_p1 <= mem[pc_p0];
    end
  end

  assign push_entry = '{pc: rd_pc_p1, word: rd_data_p1};

  // ---- stage p2: prefetch FIFO ----

  fetch_fifo #(
    .QDEPTH  (QDEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_p1),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head_entry),
    .count     (fifo_count)
  );

`ifdef FETCH_HALT_DETECT_EN
  assign halt_hit = vld_p1 & (rd_data_p1 == HALT_WORD);

  // Halt latches when the halt word leaves the read stage; redirect clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                halted_q <= 1'b0;
    else if (redirect_valid) halted_q <= 1'b0;
    else if (halt_hit)       halted_q <= 1'b1;
  end
`else
  logic unused_halt;
  assign halt_hit    = 1'b0;
  assign halted_q    = 1'b0;
  assign unused_halt = ^HALT_WORD;
`endif

endmodule
